// File: rtl/video_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_fetch_sequencer
// Description : Video timing (de/hsync/vsync) and 4-word-per-16-pixel fetch
//               controller feeding the shifter over a req/ack memory port.
//               Optional macro LINE_OFFSET_EN adds line_offset to the fetch
//               pointer at the end of every visible line.
// Revision    : 1.0 - initial release
// ============================================================================
module video_fetch_sequencer #(
    parameter int unsigned H_TOTAL      = 512,
    parameter int unsigned H_DE_START   = 112,
    parameter int unsigned H_DE_END     = 432,
    parameter int unsigned H_SYNC_START = 464,
    parameter int unsigned H_SYNC_LEN   = 40,
    parameter int unsigned V_TOTAL      = 313,
    parameter int unsigned V_DE_START   = 63,
    parameter int unsigned V_DE_END     = 263,
    parameter int unsigned V_SYNC_START = 310,
    parameter int unsigned V_SYNC_LEN   = 3
) (
    input  logic        CLOCK_32,
    input  logic        reset,
    input  logic        video_en,
    input  logic [22:0] base_addr,
    input  logic [7:0]  line_offset,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] shifter_data,
    output logic        load,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  underrun_count
);

    localparam int unsigned c_HW = $clog2(H_TOTAL);
    localparam int unsigned c_VW = $clog2(V_TOTAL);

    localparam logic [31:0]     c_H_LAST      = 32'(H_TOTAL - 1);
    localparam logic [31:0]     c_V_LAST      = 32'(V_TOTAL - 1);
    localparam logic [31:0]     c_FETCH_START = 32'(H_DE_START - 16);
    localparam logic [31:0]     c_FETCH_END   = 32'(H_DE_END - 16);
    localparam logic [c_HW-1:0] c_H_ONE       = 1;
    localparam logic [c_VW-1:0] c_V_ONE       = 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;

    logic [1:0]      r_div;
    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic [1:0]      r_state;
    logic [2:0]      r_wait;
    logic [22:0]     r_ptr;

    logic [31:0] w_h;
    logic [31:0] w_v;
    logic        w_tick;
    logic        w_vis;
    logic        w_de_next;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_vs_rise;
    logic        w_fetch_win;
    logic [1:0]  w_phase;
    logic        w_slot;
    logic [22:0] w_offset;

    assign w_h    = 32'(r_h);
    assign w_v    = 32'(r_v);
    assign w_tick = (r_div == 2'd3);

    assign w_vis     = (w_v >= V_DE_START) && (w_v < V_DE_END);
    assign w_de_next = w_vis && (w_h >= H_DE_START) && (w_h < H_DE_END);
    assign w_hs_next = (w_h >= H_SYNC_START) && (w_h < H_SYNC_START + H_SYNC_LEN);
    assign w_vs_next = (w_v >= V_SYNC_START) && (w_v < V_SYNC_START + V_SYNC_LEN);
    assign w_vs_rise = w_vs_next && !vsync;

    // Fetches run 16 ticks ahead of de so the shifter is primed at the first pixel.
    assign w_fetch_win = w_vis && (w_h >= c_FETCH_START) && (w_h < c_FETCH_END);
    assign w_phase     = w_h[1:0] - c_FETCH_START[1:0];
    assign w_slot      = w_tick && w_fetch_win && (w_phase == 2'd0) && video_en
                         && (r_state == c_IDLE);

`ifdef LINE_OFFSET_EN
    logic w_line_end;
    assign w_line_end = w_tick && w_vis && (w_h == c_H_LAST);
    assign w_offset   = w_line_end ? {15'd0, line_offset} : 23'd0;
`else
    logic w_unused_offset;
    assign w_unused_offset = ^line_offset;
    assign w_offset        = 23'd0;
`endif

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            r_div <= 2'd0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= r_div + 2'd1;
            if (w_tick) begin
                if (w_h == c_H_LAST) begin
                    r_h <= '0;
                    r_v <= (w_v == c_V_LAST) ? '0 : r_v + c_V_ONE;
                end else begin
                    r_h <= r_h + c_H_ONE;
                end
            end
        end
    end

    // Registered from the counters, so they change one CLOCK_32 after each tick.
    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            de    <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            de    <= w_de_next;
            hsync <= w_hs_next;
            vsync <= w_vs_next;
        end
    end

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            r_ptr <= 23'd0;
        end else if (w_vs_rise) begin
            r_ptr <= base_addr;
        end else begin
            r_ptr <= r_ptr + {22'd0, w_slot} + w_offset;
        end
    end

    // r_wait counts REQ cycles (timeout on the 8th) and LOAD cycles (4 strobes).
    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_wait         <= 3'd0;
            mem_req        <= 1'b0;
            mem_addr       <= 23'd0;
            shifter_data   <= 16'h0000;
            load           <= 1'b0;
            underrun_count <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_slot) begin
                        r_state  <= c_REQ;
                        r_wait   <= 3'd0;
                        mem_req  <= 1'b1;
                        mem_addr <= r_ptr;
                    end
                end
                c_REQ: begin
                    if (mem_ack) begin
                        shifter_data <= mem_data;
                        mem_req      <= 1'b0;
                        load         <= 1'b1;
                        r_wait       <= 3'd0;
                        r_state      <= c_LOAD;
                    end else if (r_wait == 3'd7) begin
                        shifter_data <= 16'h0000;
                        mem_req      <= 1'b0;
                        load         <= 1'b1;
                        r_wait       <= 3'd0;
                        r_state      <= c_LOAD;
                        if (underrun_count != 8'hFF) begin
                            underrun_count <= underrun_count + 8'd1;
                        end
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                c_LOAD: begin
                    if (r_wait == 3'd3) begin
                        load    <= 1'b0;
                        r_wait  <= 3'd0;
                        r_state <= c_IDLE;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    mem_req <= 1'b0;
                    load    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_fetch_sequencer
// Description : Self-checking bench for video_fetch_sequencer with a shortened
//               8-line frame; honours LINE_OFFSET_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_fetch_sequencer;

    localparam int LINE     = 2048;
    localparam int FRAME    = 8 * LINE;
    localparam int HS_FIRST = 1857;
    localparam int VS_FIRST = 12289;
`ifdef LINE_OFFSET_EN
    localparam logic [22:0] c_OFF       = 23'd8;
    localparam logic [22:0] c_LINE1_ADR = 23'h03C058;
`else
    localparam logic [22:0] c_OFF       = 23'd0;
    localparam logic [22:0] c_LINE1_ADR = 23'h03C050;
`endif

    logic        CLOCK_32 = 1'b0;
    logic        reset;
    logic        video_en;
    logic [22:0] base_addr;
    logic [7:0]  line_offset;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack  = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] shifter_data;
    logic        load;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [7:0]  underrun_count;

    always #5 CLOCK_32 = ~CLOCK_32;

    video_fetch_sequencer #(
        .V_TOTAL      (8),
        .V_DE_START   (2),
        .V_DE_END     (6),
        .V_SYNC_START (6),
        .V_SYNC_LEN   (2)
    ) dut (
        .CLOCK_32       (CLOCK_32),
        .reset          (reset),
        .video_en       (video_en),
        .base_addr      (base_addr),
        .line_offset    (line_offset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .shifter_data   (shifter_data),
        .load           (load),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .underrun_count (underrun_count)
    );

    typedef struct {
        int   cyc;
        logic de;
        logic hs;
        logic vs;
    } tvec_t;
    localparam int NT = 18;
    tvec_t tv [NT];

    int vec_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    bit run = 0;
    bit ack_mode = 0;

    logic [15:0] sb [$];
    logic [22:0] exp_addr = 23'd0;
    logic [22:0] held_addr;
    logic [15:0] held_data;
    logic [15:0] exp_d;
    int  exp_under = 0;
    int  line_reqs = 0, line_loads = 0;
    int  req_len = 0, load_len = 0, n_reload = 0;
    bit  reloaded = 0, cur_acked = 0, addr_moved = 0, unstable = 0;
    bit  prev_req = 0, prev_load = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard: expected words are queued when the ack/timeout is decided and
    // popped when the DUT raises load.
    always @(posedge CLOCK_32) begin
        #1;
        if (run) begin
            cyc++;
            if (cyc >= VS_FIRST && (cyc - VS_FIRST) % FRAME == 0) begin
                exp_addr = base_addr;
                reloaded = 1;
                n_reload = 0;
            end
            if (cyc >= HS_FIRST && (cyc - HS_FIRST) % LINE == 0) begin
                int  ln;
                bit  vis;
                ln  = ((cyc - HS_FIRST) / LINE) % 8;
                vis = (ln >= 2) && (ln < 6);
                chk("line_reqs", line_reqs, (vis && video_en) ? 80 : 0);
                chk("line_loads", line_loads, (vis && video_en) ? 80 : 0);
                line_reqs  = 0;
                line_loads = 0;
                if (vis) exp_addr = exp_addr + c_OFF;
            end

            if (mem_req) begin
                if (!prev_req) begin
                    req_len    = 0;
                    addr_moved = 0;
                    held_addr  = mem_addr;
                    line_reqs++;
                    chk("req_addr", mem_addr, exp_addr);
                    exp_addr = exp_addr + 23'd1;
                    if (reloaded) begin
                        if (n_reload == 0)  chk("frame_first_addr", mem_addr, 23'h03C000);
                        if (n_reload == 79) chk("line_last_addr", mem_addr, 23'h03C04F);
                        if (n_reload == 80) chk("next_line_addr", mem_addr, c_LINE1_ADR);
                        n_reload++;
                    end
                    cur_acked = ack_mode;
                    if (!ack_mode) begin
                        sb.push_back(16'h0000);
                        exp_under = (exp_under == 255) ? 255 : exp_under + 1;
                    end
                end
                req_len++;
                if (mem_addr !== held_addr) addr_moved = 1;
            end else if (prev_req) begin
                chk("req_len", req_len, cur_acked ? 2 : 8);
                chk("addr_stable", addr_moved, 0);
            end
            mem_ack = 1'b0;
            if (mem_req && cur_acked && req_len == 2) begin
                mem_data = 16'($urandom);
                mem_ack  = 1'b1;
                sb.push_back(mem_data);
            end
            prev_req = mem_req;

            if (load) begin
                if (!prev_load) begin
                    line_loads++;
                    load_len  = 0;
                    unstable  = 0;
                    held_data = shifter_data;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        exp_d = sb.pop_front();
                        chk("load_data", shifter_data, exp_d);
                    end
                    chk("underrun_count", underrun_count, exp_under);
                end
                load_len++;
                if (shifter_data !== held_data) unstable = 1;
            end else if (prev_load) begin
                chk("load_len", load_len, 4);
                chk("load_data_stable", unstable, 0);
            end
            prev_load = load;
        end
    end

    initial begin
        // {cycle after reset release, de, hsync, vsync}
        tv[0]  = '{1,     1'b0, 1'b0, 1'b0};
        tv[1]  = '{1856,  1'b0, 1'b0, 1'b0};
        tv[2]  = '{1857,  1'b0, 1'b1, 1'b0};
        tv[3]  = '{2016,  1'b0, 1'b1, 1'b0};
        tv[4]  = '{2017,  1'b0, 1'b0, 1'b0};
        tv[5]  = '{2849,  1'b0, 1'b0, 1'b0};
        tv[6]  = '{4544,  1'b0, 1'b0, 1'b0};
        tv[7]  = '{4545,  1'b1, 1'b0, 1'b0};
        tv[8]  = '{5824,  1'b1, 1'b0, 1'b0};
        tv[9]  = '{5825,  1'b0, 1'b0, 1'b0};
        tv[10] = '{5953,  1'b0, 1'b1, 1'b0};
        tv[11] = '{11041, 1'b1, 1'b0, 1'b0};
        tv[12] = '{12288, 1'b0, 1'b0, 1'b0};
        tv[13] = '{12289, 1'b0, 1'b0, 1'b1};
        tv[14] = '{13089, 1'b0, 1'b0, 1'b1};
        tv[15] = '{14337, 1'b0, 1'b0, 1'b1};
        tv[16] = '{16384, 1'b0, 1'b0, 1'b1};
        tv[17] = '{16385, 1'b0, 1'b0, 1'b0};

        reset       = 1'b1;
        video_en    = 1'b1;
        base_addr   = 23'h03C000;
        line_offset = 8'd8;
        repeat (3) @(negedge CLOCK_32);
        reset = 1'b0;

        // Let the first fetch time out, then hit reset in the middle of its load.
        for (int i = 0; i < 6000; i++) begin
            @(posedge CLOCK_32);
            #1;
            if (load) break;
        end
        chk("pre_load_seen", load, 1);
        chk("pre_underrun", underrun_count, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_load", load, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_shifter_data", shifter_data, 0);
        chk("rst_underrun", underrun_count, 0);
        chk("rst_sync", {de, hsync, vsync}, 0);
        repeat (3) @(negedge CLOCK_32);
        reset = 1'b0;
        run   = 1;

        for (int i = 0; i < NT; i++) begin
            wait (cyc >= tv[i].cyc);
            chk("tv_de", de, tv[i].de);
            chk("tv_hsync", hsync, tv[i].hs);
            chk("tv_vsync", vsync, tv[i].vs);
        end

        ack_mode = 1;
        wait (cyc >= HS_FIRST + FRAME + 3 * LINE);
        @(negedge CLOCK_32);
        video_en = 1'b0;
        wait (cyc >= FRAME + 4 * LINE + 1900);

        chk("sb_empty", sb.size(), 0);
        chk("final_underrun", underrun_count, 255);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
